// File: rtl/stream_demux4_pkg.sv
// Shared defaults for the 1:N stream demux: widths, channel count and the
// select code the lab uses to exercise the unmapped/drop path.
package stream_demux4_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_SEL_W  = 4;
    localparam int DEF_N_OUT  = 4;
    localparam int DEF_CNT_W  = 8;

    localparam logic [3:0] UNMAPPED_SEL = 4'hf;

endpackage

// File: rtl/stream_demux4_slot.sv
// One output channel of the demux: a single registered beat, its valid flag
// and a wrapping count of beats handed to the consumer.
module demux_slot
    import stream_demux4_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_cnt
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_consume;

    assign w_consume = r_valid && i_ready;

    // A load wins over a consume: the new beat replaces the one just taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (i_load) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
            if (w_consume) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/stream_demux4.sv
// Routes one input stream to N_OUT single-entry output slots by a per-beat
// select code; codes with no channel are accepted, discarded and counted.
module stream_demux4
    import stream_demux4_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int N_OUT  = DEF_N_OUT,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*CNT_W-1:0]  beat_cnt,
    output logic [CNT_W-1:0]        drop_cnt
);

    logic [N_OUT-1:0] w_hit;
    logic [N_OUT-1:0] w_load;
    logic             w_mapped;
    logic             w_sel_rdy;
    logic             w_accept;
    logic [CNT_W-1:0] r_drop;

    // One-hot decode; all-zero means the code names no channel.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (32'(in_sel) == 32'(k)) w_hit[k] = 1'b1;
        end
    end

    assign w_mapped  = |w_hit;
    assign w_sel_rdy = |(w_hit & (~out_valid | out_ready));
    assign in_ready  = !rst && (w_mapped ? w_sel_rdy : 1'b1);
    assign w_accept  = in_valid && in_ready;
    assign w_load    = w_hit & {N_OUT{w_accept}};

    // Drop counter saturates so a long run of bad codes stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= '0;
        end else if (w_accept && !w_mapped && (r_drop != '1)) begin
            r_drop <= r_drop + CNT_W'(1);
        end
    end

    assign drop_cnt = r_drop;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[k]),
            .i_data  (in_data),
            .i_ready (out_ready[k]),
            .o_data  (out_data[k*DATA_W +: DATA_W]),
            .o_valid (out_valid[k]),
            .o_cnt   (beat_cnt[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_stream_demux4.sv
// Bench for stream_demux4: queue-based channel model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_stream_demux4;
    import stream_demux4_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_data = '0;
    logic [3:0]  in_sel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [31:0] beat_cnt;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    stream_demux4 dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .beat_cnt  (beat_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Model: each channel is a queue of beats not yet taken by its consumer.
    logic [3:0] q[4][$];
    logic [3:0] m_last[4];
    int         m_bcnt[4];
    int         m_drop = 0;
    bit         m_init = 1'b0;
    bit         m_acc;
    logic [15:0] e_data;
    logic [3:0]  e_valid;
    logic [31:0] e_bcnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_rdy();
        if (rst) return 1'b0;
        if (in_sel >= 4) return 1'b1;
        return (q[in_sel].size() == 0) || out_ready[in_sel];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                q[k].delete();
                m_last[k] = '0;
                m_bcnt[k] = 0;
            end
            m_drop = 0;
            m_init = 1'b1;
        end else if (m_init) begin
            m_acc = in_valid && m_rdy();
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0 && out_ready[k]) begin
                    m_last[k] = q[k].pop_front();
                    m_bcnt[k] = (m_bcnt[k] + 1) % 256;
                end
            end
            if (m_acc) begin
                if (in_sel < 4) q[in_sel].push_back(in_data);
                else if (m_drop < 255) m_drop++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            for (int k = 0; k < 4; k++) begin
                e_valid[k]       = (q[k].size() != 0);
                e_data[k*4 +: 4] = e_valid[k] ? q[k][0] : m_last[k];
                e_bcnt[k*8 +: 8] = 8'(m_bcnt[k]);
            end
            check("in_ready", 32'(in_ready), 32'(m_rdy()));
            check("out_valid", 32'(out_valid), 32'(e_valid));
            check("out_data", 32'(out_data), 32'(e_data));
            check("beat_cnt", beat_cnt, e_bcnt);
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send(input logic [3:0] s, input logic [3:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_sel = s;
        in_data = d;
        for (int t = 0; t < 50 && !ok; t++) begin
            #1;
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        check("send accepted", 32'(ok), 32'd1);
    endtask

    initial begin
        int  r;
        bit  hold;
        hold = 1'b0;
        do_reset();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset beat_cnt", beat_cnt, 32'd0);

        // 1: one beat per channel at full rate
        out_ready = 4'hf;
        send(4'd0, 4'ha); check("t1 ch0", {out_valid[0], out_data[3:0]}, 32'h1a);
        send(4'd1, 4'hb); check("t1 ch1", {out_valid[1], out_data[7:4]}, 32'h1b);
        send(4'd2, 4'hd); check("t1 ch2", {out_valid[2], out_data[11:8]}, 32'h1d);
        send(4'd3, 4'he); check("t1 ch3", {out_valid[3], out_data[15:12]}, 32'h1e);
        step();
        check("t1 beat_cnt", beat_cnt, 32'h01010101);

        // 2: backpressure on ch2, then accept and consume on one edge
        do_reset();
        out_ready = 4'b1011;
        send(4'd2, 4'h3);
        in_valid = 1'b1; in_sel = 4'd2; in_data = 4'h7;
        #1;
        check("t2 stalled ready", 32'(in_ready), 32'd0);
        step();
        check("t2 held", {out_valid[2], out_data[11:8]}, 32'h13);
        out_ready[2] = 1'b1;
        #1;
        check("t2 released ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("t2 second beat", {out_valid[2], out_data[11:8]}, 32'h17);
        check("t2 ch2 cnt", 32'(beat_cnt[23:16]), 32'd1);

        // 3: every unmapped code is swallowed
        do_reset();
        out_ready = 4'h0;
        for (int s = 4; s < 16; s++) begin
            in_valid = 1'b1; in_sel = 4'(s); in_data = 4'(s);
            #1;
            check("t3 ready", 32'(in_ready), 32'd1);
            step();
            check("t3 out_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        check("t3 drop_cnt", 32'(drop_cnt), 32'd12);

        // 4: drop counter saturates, beat counter wraps
        do_reset();
        in_valid = 1'b1; in_sel = UNMAPPED_SEL;
        repeat (300) step();
        in_valid = 1'b0;
        check("t4 drop sat", 32'(drop_cnt), 32'hff);
        do_reset();
        out_ready = 4'hf;
        in_valid = 1'b1; in_sel = 4'd1;
        for (int i = 0; i < 257; i++) begin
            in_data = 4'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        check("t4 ch1 wrap", 32'(beat_cnt[15:8]), 32'd1);

        // 5: reset with beats parked in ch0/ch3
        out_ready = 4'h0;
        send(4'd0, 4'h5);
        send(4'd3, 4'h6);
        check("t5 parked", 32'(out_valid), 32'b1001);
        rst = 1'b1;
        in_valid = 1'b1; in_sel = 4'd1; in_data = 4'h9;
        #1;
        check("t5 ready in rst", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check("t5 out_valid", 32'(out_valid), 32'd0);
        check("t5 beat_cnt", beat_cnt, 32'd0);
        check("t5 drop_cnt", 32'(drop_cnt), 32'd0);
        out_ready = 4'hf;
        step();
        check("t5 no late beat", 32'(out_valid), 32'd0);

        // 6: random traffic; producer holds its beat until accepted
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (!hold) begin
                in_valid = (($urandom % 4) != 0);
                r = $urandom_range(0, 5);
                in_sel = (r < 4) ? 4'(r) : 4'($urandom_range(4, 15));
                in_data = 4'($urandom);
            end
            out_ready = 4'($urandom);
            #1;
            hold = in_valid && !in_ready;
            step();
        end
        in_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
